// File: rtl/cdu_pulse_relay.sv
// Multi-channel CDU angle counter and +PG/-PG increment pulse relay.
// Define CDU_OVF_FLAG_EN to build the sticky per-channel angle-wrap flag.
module cdu_pulse_relay #(
  parameter int NCH       = 3,
  parameter int ANG_W     = 16,
  parameter int PEND_W    = 6,
  parameter int PULSE_W   = 4,
  parameter int PULSE_GAP = 4
) (
  input  logic                 CLOCKH,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       UPLVL,
  input  logic [NCH-1:0]       DNLVL,
  input  logic [NCH-1:0]       CDUZ,
  output logic [NCH*ANG_W-1:0] ANGLE,
  output logic [NCH-1:0]       ATpPGH,
  output logic [NCH-1:0]       ATmPGH,
  output logic [NCH-1:0]       BUSY,
  output logic [NCH-1:0]       PEND_FULL,
  output logic [NCH-1:0]       OVF
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP
  } state_e;

  localparam int TMAX = (PULSE_W > PULSE_GAP) ? PULSE_W : PULSE_GAP;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int PMAX = 2 ** (PEND_W - 1) - 1;
  localparam int SW   = PEND_W + 2;

  localparam logic signed [SW-1:0] HI_S = SW'(PMAX);
  localparam logic signed [SW-1:0] LO_S = -HI_S;
  localparam logic signed [PEND_W-1:0] HI_P = PEND_W'(PMAX);
  localparam logic signed [PEND_W-1:0] LO_P = -HI_P;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_e                    state_q, state_d;
    logic [TW-1:0]             tmr_q, tmr_d;
    logic                      neg_q, neg_d;
    logic signed [PEND_W-1:0]  pend_q, pend_d;
    logic [ANG_W-1:0]          ang_q, ang_d;
    logic                      p_q, p_d;
    logic                      m_q, m_d;
    logic                      busy_q, busy_d;
    logic                      full_q, full_d;
    logic signed [SW-1:0]      delta, drain, sum;
    logic                      inc, dec;

    assign inc = UPLVL[g] & ~DNLVL[g];
    assign dec = DNLVL[g] & ~UPLVL[g];

    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      neg_d   = neg_q;
      drain   = '0;
      delta   = '0;
      ang_d   = ang_q;
      if (inc) begin
        delta = SW'(1);
        ang_d = ang_q + ANG_W'(1);
      end else if (dec) begin
        delta = '1;
        ang_d = ang_q - ANG_W'(1);
      end
      unique case (state_q)
        S_IDLE: begin
          if (pend_q != '0) begin
            state_d = S_PULSE;
            tmr_d   = TW'(PULSE_W - 1);
            neg_d   = pend_q[PEND_W-1];
            drain   = pend_q[PEND_W-1] ? '1 : SW'(1);
          end
        end
        S_PULSE: begin
          if (tmr_q == '0) begin
            state_d = S_GAP;
            tmr_d   = TW'(PULSE_GAP - 1);
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        S_GAP: begin
          if (tmr_q == '0) state_d = S_IDLE;
          else tmr_d = tmr_q - TW'(1);
        end
        default: state_d = S_IDLE;
      endcase
      // Sum is wide enough that saturation can be judged after the fact.
      sum = SW'(pend_q) + delta - drain;
      if (sum > HI_S) pend_d = HI_P;
      else if (sum < LO_S) pend_d = LO_P;
      else pend_d = PEND_W'(sum);
      if (CDUZ[g]) begin
        state_d = S_IDLE;
        tmr_d   = '0;
        neg_d   = 1'b0;
        pend_d  = '0;
        ang_d   = '0;
      end
      p_d    = (state_d == S_PULSE) & ~neg_d;
      m_d    = (state_d == S_PULSE) & neg_d;
      busy_d = (state_d != S_IDLE) | (pend_d != '0);
      full_d = (pend_d == HI_P) | (pend_d == LO_P);
    end

    always_ff @(posedge CLOCKH) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        tmr_q   <= '0;
        neg_q   <= 1'b0;
        pend_q  <= '0;
        ang_q   <= '0;
        p_q     <= 1'b0;
        m_q     <= 1'b0;
        busy_q  <= 1'b0;
        full_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        tmr_q   <= tmr_d;
        neg_q   <= neg_d;
        pend_q  <= pend_d;
        ang_q   <= ang_d;
        p_q     <= p_d;
        m_q     <= m_d;
        busy_q  <= busy_d;
        full_q  <= full_d;
      end
    end

    assign ANGLE[g*ANG_W +: ANG_W] = ang_q;
    assign ATpPGH[g]    = p_q;
    assign ATmPGH[g]    = m_q;
    assign BUSY[g]      = busy_q;
    assign PEND_FULL[g] = full_q;

`ifdef CDU_OVF_FLAG_EN
    logic ovf_q, ovf_d;
    logic wrap;

    assign wrap = (inc & (ang_q == '1)) | (dec & (ang_q == '0));

    always_comb begin
      ovf_d = ovf_q | wrap;
      if (CDUZ[g]) ovf_d = 1'b0;
    end

    always_ff @(posedge CLOCKH) begin
      if (!rst_n) ovf_q <= 1'b0;
      else ovf_q <= ovf_d;
    end

    assign OVF[g] = ovf_q;
`else
    assign OVF[g] = 1'b0;
`endif
  end

endmodule
